// File: rtl/sqrt_pkg.sv
// Shared types and elaboration-time helpers for the sequential square root.
//   sqrt_state_e   : controller states
//   sqrt_root_bits : root width N = (W+F)/2, also the iteration count
//   sqrt_params_ok : legal W/F combination (W+F even, F <= W-2)
//   sqrt_cnt_bits  : iteration counter width for a given N
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  function automatic int unsigned sqrt_root_bits(input int unsigned w, input int unsigned f);
    return (w + f) / 2;
  endfunction

  // F <= W-2 also guarantees the rounded N+1-bit root fits in W bits.
  function automatic bit sqrt_params_ok(input int unsigned w, input int unsigned f);
    return (((w + f) % 2) == 0) && ((f + 2) <= w);
  endfunction

  function automatic int unsigned sqrt_cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// Operand/result handshake bundle for sqrt_seq.
//   in_valid/in_ready/data_in        : operand channel (Q(W-F).F radicand)
//   out_valid/out_ready/data_out     : result channel (Q(W-F).F root)
//   rem_out                          : N+1-bit integer remainder of the truncated root
interface sqrt_seq_if
  import sqrt_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned F = 8
) ();
  localparam int unsigned N = sqrt_root_bits(W, F);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic [N:0]   rem_out;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, rem_out
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, rem_out
  );
endinterface

// File: rtl/sqrt_step.sv
// One restoring square-root digit step, purely combinational.
//   rem_i  : partial remainder before this digit
//   bits_i : next two radicand bits, MSB first
//   root_i : partial root before this digit
//   rem_o  : partial remainder after this digit
//   bit_o  : new root bit (1 when the trial subtraction does not go negative)
module sqrt_step #(
  parameter int unsigned N = 12
) (
  input  logic [N:0]   rem_i,
  input  logic [1:0]   bits_i,
  input  logic [N-1:0] root_i,
  output logic [N:0]   rem_o,
  output logic         bit_o
);
  // Shifted remainder can reach 8*root+3, hence two guard bits above N+1.
  localparam int unsigned XW = N + 3;

  logic [XW-1:0] shifted_c;
  logic [XW-1:0] trial_c;
  logic [XW-1:0] diff_c;

  always_comb begin
    shifted_c = {rem_i, bits_i};
    trial_c   = XW'({root_i, 2'b01});
    diff_c    = shifted_c - trial_c;
    bit_o     = (shifted_c >= trial_c);
    // Either result is bounded by 2*new_root, so N+1 bits always suffice.
    rem_o     = (N+1)'(bit_o ? diff_c : shifted_c);
  end
endmodule

// File: rtl/sqrt_seq.sv
// Sequential unsigned fixed-point square root, one root bit per cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : sqrt_seq_if slave; accepts a radicand in IDLE, presents
//                floor(sqrt(data_in*2^F)) (or rounded when ROUND=1) and the
//                remainder of the truncated root until consumed.
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned F     = 8,
  parameter int unsigned ROUND = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  sqrt_seq_if.slave bus
);
  localparam int unsigned N  = sqrt_root_bits(W, F);
  localparam int unsigned RW = 2 * N;
  localparam int unsigned CW = sqrt_cnt_bits(N);

  if (!sqrt_params_ok(W, F)) begin : g_bad_params
    $error("sqrt_seq: W+F must be even and F <= W-2");
  end

  sqrt_state_e   state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [RW-1:0] rad_q,       rad_d;
  logic [N:0]    rem_q,       rem_d;
  logic [N-1:0]  root_q,      root_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  data_out_q,  data_out_d;
  logic [N:0]    rem_out_q,   rem_out_d;

  logic [N:0]    step_rem_c;
  logic          step_bit_c;
  logic [N-1:0]  root_next_c;
  logic [N:0]    rounded_c;

  // Single shared digit step, fed from the top two radicand bits.
  sqrt_step #(.N(N)) u_step (
    .rem_i  (rem_q),
    .bits_i (rad_q[RW-1 -: 2]),
    .root_i (root_q),
    .rem_o  (step_rem_c),
    .bit_o  (step_bit_c)
  );

  // Root after this digit, and its round-to-nearest variant (rem > root).
  always_comb begin
    root_next_c = (root_q << 1) | N'(step_bit_c);
    rounded_c   = {1'b0, root_next_c} + (N+1)'(step_rem_c > {1'b0, root_next_c});
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    data_out_d = data_out_q;
    rem_out_d  = rem_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rad_d   = RW'(bus.data_in) << F;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(N - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem_c;
        root_d = root_next_c;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Result latched on DONE entry so rounding costs no extra cycle.
          data_out_d = (ROUND != 0) ? W'(rounded_c) : W'(root_next_c);
          rem_out_d  = step_rem_c;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      rem_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      rem_out_q   <= rem_out_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.rem_out   = rem_out_q;
endmodule
